cache_controller_dm: RTL and testbench
======================================

// Module: cache_controller_dm
// PURPOSE
//   Direct-mapped, write-back, write-allocate data cache sitting between the CPU request
//   stage and main memory. The CPU presents one request per cycle (no valid strobe) and
//   advances on the posedge where hit_miss=1. Misses stall the CPU while the controller
//   writes back a dirty victim block, then refills from memory over a block-wide handshake.
// PARAMETERS
//   INDEX_BITS  2  log2(number of cache blocks); block = 4 words x 32b; tag = 6-INDEX_BITS bits
// PORTS
//   clock           in   1    system clock, all state updates on posedge
//   reset_n         in   1    asynchronous, active-low reset
//   read_write      in   1    0 = read, 1 = write
//   address         in   10   byte address: [1:0] byte (ignored), [3:2] word, [3+INDEX_BITS:4] index, [9:4+INDEX_BITS] tag
//   write_data      in   32   store data, used when read_write=1
//   hit_miss        out  1    1 = request completes at this posedge (combinational)
//   read_data       out  32   cached word when hit_miss=1 and read_write=0, else 0
//   mem_read        out  1    block refill request, held until mem_ready sampled high
//   mem_write       out  1    block write-back request, held until mem_ready sampled high
//   mem_address     out  10   block-aligned byte address ([3:0]=0); 0 when idle
//   mem_write_data  out  128  victim block; word i on bits [32i+31:32i]; 0 when idle
//   mem_read_data   in   128  refill block, same word ordering, valid when mem_ready=1
//   mem_ready       in   1    one-cycle completion pulse for the pending mem_read/mem_write
// BEHAVIOUR
//   - State: per block valid, dirty, tag, 4x32b data. FSM: COMPARE, WRITE_BACK, ALLOCATE.
//   - Reset (async, reset_n=0): state=COMPARE; all valid=0, dirty=0; mem_read=mem_write=0,
//     mem_address=0, mem_write_data=0; hit_miss=0, read_data=0. Data/tag arrays not cleared.
//   - COMPARE: hit = valid[idx] && tag[idx]==addr tag; hit_miss=hit (combinational, same cycle).
//     Read hit: read_data = data[idx][word]. Write hit: at posedge write word, dirty[idx]=1.
//     Miss: posedge -> WRITE_BACK if valid&&dirty, else ALLOCATE. No memory traffic on hit.
//   - WRITE_BACK: mem_write=1, mem_address={victim tag, idx, 4'b0}, mem_write_data=victim block.
//     Hold all mem outputs stable; on posedge with mem_ready=1 -> ALLOCATE, dirty[idx]=0.
//   - ALLOCATE: mem_read=1, mem_address={addr[9:4], 4'b0}. On posedge with mem_ready=1:
//     data[idx]=mem_read_data, tag updated, valid=1, dirty=0 -> COMPARE.
//   - After refill, request re-evaluated in COMPARE and hits next cycle (write applied there).
//   - hit_miss=0 in WRITE_BACK/ALLOCATE. mem_read and mem_write never both 1.
//   - Latency: hit 1 cycle; clean miss = 1 + refill wait + 1; dirty miss adds write-back wait.
//   - mem_ready while neither mem_read nor mem_write asserted: ignored.
//   - CPU must hold address/read_write/write_data stable while hit_miss=0; change mid-miss undefined.
//   - Reset mid-WRITE_BACK/ALLOCATE: transaction abandoned, mem_* drop immediately, all lines
//     invalid; pending request re-issued from COMPARE after reset release.
//   - Byte offset ignored: all accesses are word-wide; no misalignment detection.
// TESTING
//   1 Reset, read 10'b0110101001 -> hit_miss=0, mem_read=1, mem_address=10'b0110100000; memory
//     returns block with word2=32'hA5A5_0002 after 3 cycles -> next cycle hit_miss=1, read_data=32'hA5A5_0002.
//   2 Write 32'h0000_0fac to 10'b0110010101 (clean miss) -> refill from 10'b0110010000 only,
//     no mem_write; then hit_miss=1, line 1 dirty.
//   3 Read 10'b0110010101 -> hit_miss=1 same cycle, read_data=32'h0000_0fac, mem_read=mem_write=0.
//   4 Read 10'b0101010100 (conflict, dirty) -> mem_write=1, mem_address=10'b0110010000,
//     mem_write_data[63:32]=32'h0000_0fac; then mem_read at 10'b0101010000; then hit.
//   5 Read 10'b0110010101 again -> clean eviction (no mem_write), refill, read_data=32'h0000_0fac.
//   6 Assert reset_n=0 during ALLOCATE with mem_ready pending -> mem_read=0 immediately;
//     after release, same address misses and restarts refill; late mem_ready pulse ignored.

Source files
------------

// File: rtl/cache_controller_dm.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Sits between the CPU request stage and main memory. The CPU holds its request
// until hit_miss=1. A miss first writes back a dirty victim block, then refills the
// block from memory, and then re-evaluates the request in COMPARE, where it hits.
module cache_controller_dm #(
  parameter int INDEX_BITS = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         read_write,
  input  logic [9:0]   address,
  input  logic [31:0]  write_data,
  output logic         hit_miss,
  output logic [31:0]  read_data,
  output logic         mem_read,
  output logic         mem_write,
  output logic [9:0]   mem_address,
  output logic [127:0] mem_write_data,
  input  logic [127:0] mem_read_data,
  input  logic         mem_ready
);

  localparam int TAG_BITS   = 6 - INDEX_BITS;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  localparam logic [1:0] ST_COMPARE    = 2'd0;
  localparam logic [1:0] ST_WRITE_BACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE   = 2'd2;

  logic [1:0]            state_r;
  logic [1:0]            next_state_s;
  logic [NUM_BLOCKS-1:0] valid_r;
  logic [NUM_BLOCKS-1:0] dirty_r;
  logic [TAG_BITS-1:0]   tag_r  [NUM_BLOCKS];
  logic [127:0]          data_r [NUM_BLOCKS];

  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0]   req_tag_s;
  logic [1:0]            word_s;
  logic                  hit_s;
  logic [31:0]           hit_word_s;
  logic                  wr_hit_s;
  logic                  wb_done_s;
  logic                  fill_s;
  logic                  unused_byte_s;

  // Address fields; the byte offset plays no role because every access is word-wide.
  assign idx_s         = address[3+INDEX_BITS:4];
  assign req_tag_s     = address[9:4+INDEX_BITS];
  assign word_s        = address[3:2];
  assign unused_byte_s = ^address[1:0];

  assign hit_s      = valid_r[idx_s] && (tag_r[idx_s] == req_tag_s);
  assign hit_word_s = data_r[idx_s][{word_s, 5'b00000} +: 32];

  // Array update strobes: store on write hit, victim cleaned on write-back ack, refill on read ack.
  assign wr_hit_s  = (state_r == ST_COMPARE) && hit_s && read_write;
  assign wb_done_s = (state_r == ST_WRITE_BACK) && mem_ready;
  assign fill_s    = (state_r == ST_ALLOCATE) && mem_ready;

  // Output decode and next-state selection; mem_* are pure functions of state so reset drops them at once.
  always_comb begin
    next_state_s   = state_r;
    hit_miss       = 1'b0;
    read_data      = 32'h0000_0000;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 10'd0;
    mem_write_data = 128'd0;
    case (state_r)
      ST_COMPARE: begin
        hit_miss = hit_s;
        if (hit_s && !read_write) begin
          read_data = hit_word_s;
        end else begin
          read_data = 32'h0000_0000;
        end
        if (hit_s) begin
          next_state_s = ST_COMPARE;
        end else if (valid_r[idx_s] && dirty_r[idx_s]) begin
          next_state_s = ST_WRITE_BACK;
        end else begin
          next_state_s = ST_ALLOCATE;
        end
      end
      ST_WRITE_BACK: begin
        mem_write      = 1'b1;
        mem_address    = {tag_r[idx_s], idx_s, 4'b0000};
        mem_write_data = data_r[idx_s];
        if (mem_ready) begin
          next_state_s = ST_ALLOCATE;
        end else begin
          next_state_s = ST_WRITE_BACK;
        end
      end
      ST_ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = {address[9:4], 4'b0000};
        if (mem_ready) begin
          next_state_s = ST_COMPARE;
        end else begin
          next_state_s = ST_ALLOCATE;
        end
      end
      default: begin
        next_state_s = ST_COMPARE;
      end
    endcase
  end

  // Controller state and per-line valid/dirty flags; reset invalidates every line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_COMPARE;
      valid_r <= {NUM_BLOCKS{1'b0}};
      dirty_r <= {NUM_BLOCKS{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (wr_hit_s) begin
        dirty_r[idx_s] <= 1'b1;
      end else if (wb_done_s) begin
        dirty_r[idx_s] <= 1'b0;
      end else if (fill_s) begin
        valid_r[idx_s] <= 1'b1;
        dirty_r[idx_s] <= 1'b0;
      end
    end
  end

  // Tag and data arrays; contents are meaningless until the line is marked valid, so no reset.
  always_ff @(posedge clock) begin
    if (wr_hit_s) begin
      data_r[idx_s][{word_s, 5'b00000} +: 32] <= write_data;
    end else if (fill_s) begin
      data_r[idx_s] <= mem_read_data;
      tag_r[idx_s]  <= req_tag_s;
    end
  end

endmodule

// File: tb/tb_cache_controller_dm.sv
// Self-checking bench for cache_controller_dm.
// The reference keeps an architectural view of memory (what the CPU must read back),
// the backing memory contents, and a tag directory. From those it derives, per request,
// the exact per-cycle output sequence, which one compare process checks every cycle.
module tb_cache_controller_dm;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         read_write;
  logic [9:0]   address;
  logic [31:0]  write_data;
  logic         hit_miss;
  logic [31:0]  read_data;
  logic         mem_read;
  logic         mem_write;
  logic [9:0]   mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;
  logic         mem_ready;

  cache_controller_dm dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .read_write     (read_write),
    .address        (address),
    .write_data     (write_data),
    .hit_miss       (hit_miss),
    .read_data      (read_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         hm;
    logic [31:0]  rd;
    logic         mr;
    logic         mw;
    logic [9:0]   ma;
    logic [127:0] mwd;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Observation log kept by the compare process for the literal checks.
  int           wr_cycles    = 0;
  logic [9:0]   last_rd_addr = 10'd0;
  logic [9:0]   last_wr_addr = 10'd0;
  logic [127:0] last_wr_data = 128'd0;

  // Reference state: architectural memory, backing memory, tag directory.
  logic [127:0] arch_blk [64];
  logic [127:0] main_mem [64];
  logic         m_valid  [4];
  logic         m_dirty  [4];
  logic [3:0]   m_tag    [4];

  // Values the next cycle applies to the DUT.
  logic         next_rst;
  logic         cur_rw;
  logic [9:0]   cur_addr;
  logic [31:0]  cur_wd;

  function automatic exp_t mk(input logic hm, input logic [31:0] rd, input logic mr,
                              input logic mw, input logic [9:0] ma, input logic [127:0] mwd);
    exp_t e;
    e.hm = hm; e.rd = rd; e.mr = mr; e.mw = mw; e.ma = ma; e.mwd = mwd;
    return e;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Per-cycle compare of every DUT output against the expected record for that cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (hit_miss !== e.hm || read_data !== e.rd || mem_read !== e.mr ||
          mem_write !== e.mw || mem_address !== e.ma || mem_write_data !== e.mwd) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got hm=%0b rd=%h mr=%0b mw=%0b ma=%b mwd=%h required hm=%0b rd=%h mr=%0b mw=%0b ma=%b mwd=%h",
                 $time, hit_miss, read_data, mem_read, mem_write, mem_address, mem_write_data,
                 e.hm, e.rd, e.mr, e.mw, e.ma, e.mwd);
      end
      if (mem_write === 1'b1) begin
        wr_cycles++;
        last_wr_addr = mem_address;
        last_wr_data = mem_write_data;
      end
      if (mem_read === 1'b1) begin
        last_rd_addr = mem_address;
      end
    end
  end

  task automatic check_lit(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // One clock cycle: drive inputs just after the edge and queue what the outputs must be.
  task automatic cycle(input exp_t e, input logic rdy, input logic [127:0] rdat);
    @(posedge clock);
    #1;
    reset_n       = next_rst;
    read_write    = cur_rw;
    address       = cur_addr;
    write_data    = cur_wd;
    mem_ready     = rdy;
    mem_read_data = rdat;
    exp_q.push_back(e);
  endtask

  // One CPU request from presentation until completion, with chosen memory wait times.
  task automatic req(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                     input int wbw, input int alw, input logic stray);
    logic [1:0] idx;
    logic [3:0] tg;
    logic [5:0] blk;
    logic [5:0] vb;
    int         wo;
    idx = a[5:4];
    tg  = a[9:6];
    blk = a[9:4];
    wo  = int'(a[3:2]) * 32;
    cur_rw = rw; cur_addr = a; cur_wd = wd;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      cycle(mk(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 128'd0), stray, rnd128());
      if (m_valid[idx] && m_dirty[idx]) begin
        vb = {m_tag[idx], idx};
        for (int i = 0; i <= wbw; i++) begin
          cycle(mk(1'b0, 32'd0, 1'b0, 1'b1, {vb, 4'b0000}, arch_blk[vb]), (i == wbw), rnd128());
        end
        main_mem[vb] = arch_blk[vb];
        m_dirty[idx] = 1'b0;
      end
      for (int i = 0; i <= alw; i++) begin
        cycle(mk(1'b0, 32'd0, 1'b1, 1'b0, {blk, 4'b0000}, 128'd0), (i == alw),
              (i == alw) ? main_mem[blk] : rnd128());
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    cycle(mk(1'b1, rw ? 32'd0 : arch_blk[blk][wo +: 32], 1'b0, 1'b0, 10'd0, 128'd0), stray, rnd128());
    if (rw) begin
      arch_blk[blk][wo +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int b = 0; b < 64; b++) begin
      arch_blk[b] = main_mem[b];
    end
  endtask

  // Read that is interrupted by reset during refill, then re-issued after release.
  task automatic reset_mid(input logic [9:0] a, input int pre);
    logic [5:0] blk;
    blk = a[9:4];
    cur_rw = 1'b0; cur_addr = a; cur_wd = 32'd0;
    cycle(mk(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 128'd0), 1'b0, rnd128());
    for (int i = 0; i < pre; i++) begin
      cycle(mk(1'b0, 32'd0, 1'b1, 1'b0, {blk, 4'b0000}, 128'd0), 1'b0, rnd128());
    end
    next_rst = 1'b0;
    cycle(mk(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 128'd0), 1'b1, main_mem[blk]);
    #1;
    check_lit("t6_mem_read_drop", {127'd0, mem_read}, 128'd0);
    cycle(mk(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 128'd0), 1'b0, rnd128());
    model_reset();
    next_rst = 1'b1;
    req(1'b0, a, 32'd0, 0, 1, 1'b1);
  endtask

  initial begin
    int           wc;
    logic [127:0] blk_v;
    logic [31:0]  word_v;
    logic [9:0]   ra;
    reset_n = 1'b0; read_write = 1'b0; address = 10'd0; write_data = 32'd0;
    mem_ready = 1'b0; mem_read_data = 128'd0;
    next_rst = 1'b0; cur_rw = 1'b0; cur_addr = 10'd0; cur_wd = 32'd0;
    for (int b = 0; b < 64; b++) begin
      main_mem[b] = rnd128();
    end
    blk_v = main_mem[6'b011010];
    blk_v[95:64] = 32'hA5A5_0002;
    main_mem[6'b011010] = blk_v;
    model_reset();

    // Reset state.
    cycle(mk(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 128'd0), 1'b0, 128'd0);
    cycle(mk(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 128'd0), 1'b1, 128'd0);
    next_rst = 1'b1;

    // 1: cold read miss, refill after 3 cycles, then hit.
    req(1'b0, 10'b0110101001, 32'd0, 0, 2, 1'b0);
    #1;
    check_lit("t1_hit", {127'd0, hit_miss}, 128'd1);
    check_lit("t1_rdata", {96'd0, read_data}, {96'd0, 32'hA5A5_0002});
    check_lit("t1_refill_addr", {118'd0, last_rd_addr}, {118'd0, 10'b0110100000});

    // 2: write to a clean miss: refill only, no write-back.
    wc = wr_cycles;
    req(1'b1, 10'b0110010101, 32'h0000_0fac, 0, 1, 1'b0);
    #1;
    check_lit("t2_hit", {127'd0, hit_miss}, 128'd1);
    check_lit("t2_refill_addr", {118'd0, last_rd_addr}, {118'd0, 10'b0110010000});
    check_lit("t2_no_writeback", 128'(wr_cycles - wc), 128'd0);

    // 3: read hit on the line just written.
    req(1'b0, 10'b0110010101, 32'd0, 0, 0, 1'b1);
    #1;
    check_lit("t3_hit", {127'd0, hit_miss}, 128'd1);
    check_lit("t3_rdata", {96'd0, read_data}, {96'd0, 32'h0000_0fac});
    check_lit("t3_no_mem", {126'd0, mem_read, mem_write}, 128'd0);

    // 4: conflict with the dirty line: write-back, refill, hit.
    req(1'b0, 10'b0101010100, 32'd0, 2, 1, 1'b0);
    word_v = last_wr_data[63:32];
    check_lit("t4_wb_addr", {118'd0, last_wr_addr}, {118'd0, 10'b0110010000});
    check_lit("t4_wb_word1", {96'd0, word_v}, {96'd0, 32'h0000_0fac});
    check_lit("t4_refill_addr", {118'd0, last_rd_addr}, {118'd0, 10'b0101010000});

    // 5: clean eviction back to the original block; data came back through memory.
    wc = wr_cycles;
    req(1'b0, 10'b0110010101, 32'd0, 0, 1, 1'b0);
    #1;
    check_lit("t5_rdata", {96'd0, read_data}, {96'd0, 32'h0000_0fac});
    check_lit("t5_no_writeback", 128'(wr_cycles - wc), 128'd0);

    // 6: reset during refill with mem_ready pending; request restarts after release.
    reset_mid(10'b1111110000, 2);
    check_lit("t6_refill_addr", {118'd0, last_rd_addr}, {118'd0, 10'b1111110000});

    // Randomized traffic over a few tags per index so conflicts and dirty evictions are common.
    for (int n = 0; n < 300; n++) begin
      ra = 10'($urandom);
      ra[9:8] = 2'b00;
      req(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    @(negedge clock);
    #1;
    check_lit("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
